// File: rtl/alu_operand_if.sv
// Handshake and operand bus between decode and the ALU operand stage.
// The stage owns the slave view; whatever feeds and drains it owns the master view.
interface alu_operand_if #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 4
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [DATA_W-1:0] in_rn_data;
   logic [DATA_W-1:0] in_rm_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [CTRL_W-1:0] out_control;
   logic [DATA_W-1:0] out_store_data;
   logic [4:0]        out_rd;
   logic              out_illegal;

   modport slave (
      input  flush, in_valid, in_instr, in_rn_data, in_rm_data, out_ready,
      output in_ready, out_valid, out_a, out_b, out_control, out_store_data,
             out_rd, out_illegal
   );

   modport master (
      output flush, in_valid, in_instr, in_rn_data, in_rm_data, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_control, out_store_data,
             out_rd, out_illegal
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode-to-execute stage in front of the 64-bit ALU. Decodes one LEGv8
// instruction per handshake into an ALU control code and an A/B operand pair,
// and holds the result in a single register slot with zero-bubble flow control.
module alu_operand_stage #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_operand_if.slave bus
);

   localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
   localparam logic [CTRL_W-1:0] CTRL_ORR = 4'b0001;
   localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
   localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
   localparam logic [CTRL_W-1:0] CTRL_PSB = 4'b0111;

   typedef enum logic [1:0] {
      BSEL_RM     = 2'd0,
      BSEL_SEXT9  = 2'd1,
      BSEL_ZEXT12 = 2'd2
   } bsel_e;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      bsel_e             bsel;
      logic              store;
      logic              illegal;
   } dec_t;

   // Opcode table lookup; unknown opcodes fall back to an ADD of Rn and Rm
   // and are flagged so the pipeline can raise an exception later.
   function automatic dec_t decode_op(input logic [31:0] instr);
      dec_t d;
      d.ctrl    = CTRL_ADD;
      d.bsel    = BSEL_RM;
      d.store   = 1'b0;
      d.illegal = 1'b0;
      casez (instr[31:21])
         11'b10001011000: d.ctrl = CTRL_ADD;
         11'b11001011000: d.ctrl = CTRL_SUB;
         11'b10001010000: d.ctrl = CTRL_AND;
         11'b10101010000: d.ctrl = CTRL_ORR;
         11'b11111000010: d.bsel = BSEL_SEXT9;
         11'b11111000000: begin
            d.bsel  = BSEL_SEXT9;
            d.store = 1'b1;
         end
         11'b1001000100?: d.bsel = BSEL_ZEXT12;
         11'b1101000100?: begin
            d.ctrl = CTRL_SUB;
            d.bsel = BSEL_ZEXT12;
         end
         11'b1001001000?: begin
            d.ctrl = CTRL_AND;
            d.bsel = BSEL_ZEXT12;
         end
         11'b1011001000?: begin
            d.ctrl = CTRL_ORR;
            d.bsel = BSEL_ZEXT12;
         end
         // CBZ and CBNZ differ only in bit 24; both pass Rt through B so
         // the ALU zero flag resolves the branch.
         11'b1011010????: d.ctrl = CTRL_PSB;
         default:         d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   logic              valid_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] store_q;
   logic [4:0]        rd_q;
   logic              illegal_q;

   dec_t              dec_d;
   logic [DATA_W-1:0] b_d;
   logic [DATA_W-1:0] store_d;
   logic              ready_d;
   logic              accept_d;

   // Handshake: the slot frees up in the same cycle it is drained.
   always_comb begin
      ready_d  = !valid_q || bus.out_ready;
      accept_d = bus.in_valid && ready_d;
   end

   // Decode the offered instruction and build the B operand and store data.
   always_comb begin
      dec_d   = decode_op(bus.in_instr);
      b_d     = bus.in_rm_data;
      store_d = '0;
      case (dec_d.bsel)
         BSEL_RM:     b_d = bus.in_rm_data;
         BSEL_SEXT9:  b_d = {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
         BSEL_ZEXT12: b_d = {{(DATA_W-12){1'b0}}, bus.in_instr[21:10]};
         default:     b_d = bus.in_rm_data;
      endcase
      if (dec_d.store) begin
         store_d = bus.in_rm_data;
      end else begin
         store_d = '0;
      end
   end

   // Operand register: reset beats flush, flush beats accept; a flushed
   // slot keeps its stale data but is no longer valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         ctrl_q    <= CTRL_ADD;
         store_q   <= '0;
         rd_q      <= 5'd0;
         illegal_q <= 1'b0;
      end else if (bus.flush) begin
         valid_q   <= 1'b0;
      end else if (accept_d) begin
         valid_q   <= 1'b1;
         a_q       <= bus.in_rn_data;
         b_q       <= b_d;
         ctrl_q    <= dec_d.ctrl;
         store_q   <= store_d;
         rd_q      <= bus.in_instr[4:0];
         illegal_q <= dec_d.illegal;
      end else if (valid_q && bus.out_ready) begin
         valid_q   <= 1'b0;
      end else begin
         valid_q   <= valid_q;
      end
   end

   assign bus.in_ready       = ready_d;
   assign bus.out_valid      = valid_q;
   assign bus.out_a          = a_q;
   assign bus.out_b          = b_q;
   assign bus.out_control    = ctrl_q;
   assign bus.out_store_data = store_q;
   assign bus.out_rd         = rd_q;
   assign bus.out_illegal    = illegal_q;

endmodule
